// File: rtl/ctrl_bm_v2.sv
// rtl/ctrl_bm_v2.sv - Bin_Manager sequencer with per-stage watchdog, backtrack budget and abort
module ctrl_bm_v2 #(
   parameter int WIDTH_BIN_ID  = 10,
   parameter int WIDTH_CLAUSES = 16,
   parameter int WIDTH_LVL     = 16,
   parameter int WIDTH_CNT     = 32,
   parameter int TIMEOUT_CYC   = 0,
   parameter int MAX_BKT       = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_bm_i,
   input  logic                     abort_i,
   output logic                     done_bm_o,
   output logic [1:0]               status_o,
   output logic [WIDTH_BIN_ID-1:0]  cur_bin_num_o,
   output logic [WIDTH_BIN_ID-1:0]  request_bin_num_o,
   output logic [WIDTH_LVL-1:0]     cur_lvl_o,
   output logic [WIDTH_CNT-1:0]     bkt_cnt_o,
   output logic [WIDTH_CNT-1:0]     load_cnt_o,
   output logic                     start_rdinfo_o,
   input  logic                     done_rdinfo_i,
   input  logic [WIDTH_CLAUSES-1:0] nbin_all_i,
   output logic                     start_load_o,
   input  logic                     done_load_i,
   output logic                     start_core_o,
   input  logic                     done_core_i,
   input  logic                     local_sat_i,
   input  logic [WIDTH_LVL-1:0]     cur_lvl_from_core_i,
   input  logic [WIDTH_BIN_ID-1:0]  bkt_bin_from_core_i,
   output logic                     start_find_o,
   input  logic                     done_find_i,
   input  logic [WIDTH_LVL-1:0]     bkt_lvl_from_find_i,
   input  logic [WIDTH_BIN_ID-1:0]  bkt_bin_from_find_i,
   output logic                     start_bkt_across_bin_o,
   input  logic                     done_bkt_across_bin_i,
   output logic                     start_update_o,
   input  logic                     done_update_i
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_INFO = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_CORE    = 3'd3;
   localparam logic [2:0] S_FIND    = 3'd4;
   localparam logic [2:0] S_BKT     = 3'd5;
   localparam logic [2:0] S_UPDATE  = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   localparam logic [1:0] ST_NONE  = 2'd0;
   localparam logic [1:0] ST_SAT   = 2'd1;
   localparam logic [1:0] ST_UNSAT = 2'd2;
   localparam logic [1:0] ST_ABORT = 2'd3;

   logic [2:0]               state, state_nxt;
   logic [1:0]               status_nxt;
   logic                     fresh;
   logic [WIDTH_CNT-1:0]     stage_cnt;
   logic [WIDTH_CLAUSES-1:0] nbin_all;
   logic [WIDTH_BIN_ID-1:0]  cur_bin, next_bin;
   logic                     active, done_in, accept, timeout, bkt_limit, last_bin;

   assign cur_bin_num_o     = cur_bin;
   assign request_bin_num_o = cur_bin;
   assign active    = (state != S_IDLE) && (state != S_DONE);
   assign accept    = done_in && !abort_i;
   assign timeout   = active && (TIMEOUT_CYC != 0) && (stage_cnt == WIDTH_CNT'(TIMEOUT_CYC - 1));
   assign bkt_limit = (MAX_BKT != 0) && (bkt_cnt_o == WIDTH_CNT'(MAX_BKT));
   assign last_bin  = (WIDTH_CLAUSES'(cur_bin) == nbin_all);

   // The entry cycle precedes the start pulse, so a done there cannot belong to this stage.
   always_comb begin
      done_in = 1'b0;
      case (state)
         S_RD_INFO: done_in = done_rdinfo_i;
         S_LOAD:    done_in = done_load_i;
         S_CORE:    done_in = done_core_i;
         S_FIND:    done_in = done_find_i;
         S_BKT:     done_in = done_bkt_across_bin_i;
         S_UPDATE:  done_in = done_update_i;
         default:   done_in = 1'b0;
      endcase
      if (fresh) done_in = 1'b0;
   end

   always_comb begin
      state_nxt  = state;
      status_nxt = status_o;
      if (active && abort_i) begin
         state_nxt  = S_DONE;
         status_nxt = ST_ABORT;
      end else if (done_in) begin
         case (state)
            S_RD_INFO: begin
               state_nxt = (nbin_all_i == '0) ? S_DONE : S_LOAD;
               if (nbin_all_i == '0) status_nxt = ST_SAT;
            end
            S_LOAD: state_nxt = S_CORE;
            S_CORE: begin
               if (local_sat_i) begin
                  state_nxt = last_bin ? S_DONE : S_UPDATE;
                  if (last_bin) status_nxt = ST_SAT;
               end else begin
                  state_nxt = (bkt_bin_from_core_i == '0) ? S_DONE : S_FIND;
                  if (bkt_bin_from_core_i == '0) status_nxt = ST_UNSAT;
               end
            end
            S_FIND: begin
               state_nxt = bkt_limit ? S_DONE : S_BKT;
               if (bkt_limit) status_nxt = ST_ABORT;
            end
            S_BKT:    state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = S_LOAD;
            default:  state_nxt = state;
         endcase
      end else if (timeout) begin
         state_nxt  = S_DONE;
         status_nxt = ST_ABORT;
      end else if (!active && start_bm_i) begin
         state_nxt  = S_RD_INFO;
         status_nxt = ST_NONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         fresh     <= 1'b0;
         stage_cnt <= '0;
         nbin_all  <= '0;
         cur_bin   <= '0;
         next_bin  <= '0;
         cur_lvl_o <= '0;
         bkt_cnt_o <= '0;
         load_cnt_o <= '0;
         status_o  <= ST_NONE;
         done_bm_o <= 1'b0;
         start_rdinfo_o <= 1'b0;
         start_load_o   <= 1'b0;
         start_core_o   <= 1'b0;
         start_find_o   <= 1'b0;
         start_bkt_across_bin_o <= 1'b0;
         start_update_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         status_o  <= status_nxt;
         done_bm_o <= (state_nxt == S_DONE);
         start_rdinfo_o <= 1'b0;
         start_load_o   <= 1'b0;
         start_core_o   <= 1'b0;
         start_find_o   <= 1'b0;
         start_bkt_across_bin_o <= 1'b0;
         start_update_o <= 1'b0;
         if (state_nxt != state) begin
            fresh     <= 1'b1;
            stage_cnt <= '0;
         end else begin
            fresh <= 1'b0;
            if (active) stage_cnt <= stage_cnt + 1'b1;
            if (fresh) begin
               case (state)
                  S_RD_INFO: start_rdinfo_o <= 1'b1;
                  S_LOAD: begin
                     start_load_o <= 1'b1;
                     load_cnt_o   <= load_cnt_o + 1'b1;
                  end
                  S_CORE:   start_core_o <= 1'b1;
                  S_FIND:   start_find_o <= 1'b1;
                  S_BKT:    start_bkt_across_bin_o <= 1'b1;
                  S_UPDATE: start_update_o <= 1'b1;
                  default: ;
               endcase
            end
         end
         if (!active && state_nxt == S_RD_INFO) begin
            cur_bin    <= WIDTH_BIN_ID'(1);
            cur_lvl_o  <= '0;
            bkt_cnt_o  <= '0;
            load_cnt_o <= '0;
         end
         if (accept) begin
            case (state)
               S_RD_INFO: nbin_all <= nbin_all_i;
               S_CORE: begin
                  if (local_sat_i) begin
                     cur_lvl_o <= cur_lvl_from_core_i;
                     next_bin  <= cur_bin + 1'b1;
                  end
               end
               S_FIND: begin
                  next_bin  <= bkt_bin_from_find_i;
                  cur_lvl_o <= bkt_lvl_from_find_i;
                  if (!bkt_limit) bkt_cnt_o <= bkt_cnt_o + 1'b1;
               end
               S_UPDATE: cur_bin <= next_bin;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ctrl_bm_v2.sv
// tb/tb_ctrl_bm_v2.sv - self-checking bench for ctrl_bm_v2
module tb_ctrl_bm_v2;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_bm_i = 1'b0, abort_i = 1'b0;
   logic        done_bm_o;
   logic [1:0]  status_o;
   logic [9:0]  cur_bin_num_o, request_bin_num_o;
   logic [15:0] cur_lvl_o;
   logic [31:0] bkt_cnt_o, load_cnt_o;
   logic        start_rdinfo_o, done_rdinfo_i = 1'b0;
   logic [15:0] nbin_all_i = 16'd0;
   logic        start_load_o, done_load_i = 1'b0;
   logic        start_core_o, done_core_i = 1'b0, local_sat_i = 1'b0;
   logic [15:0] cur_lvl_from_core_i = 16'd0;
   logic [9:0]  bkt_bin_from_core_i = 10'd0;
   logic        start_find_o, done_find_i = 1'b0;
   logic [15:0] bkt_lvl_from_find_i = 16'd0;
   logic [9:0]  bkt_bin_from_find_i = 10'd0;
   logic        start_bkt_across_bin_o, done_bkt_across_bin_i = 1'b0;
   logic        start_update_o, done_update_i = 1'b0;

   int checks = 0, errors = 0;
   int find_cnt = 0, wide_cnt = 0, load_timer = -1, load_delay = 0;
   logic load_hang = 1'b0, core_hang = 1'b0, update_hang = 1'b0, core_always_unsat = 1'b0, stray_update = 1'b0;
   logic [5:0]  st, st_prev = 6'd0;
   logic        core_sat_q[$];
   logic [15:0] core_lvl_q[$];
   logic [9:0]  core_bkt_q[$];
   logic [9:0]  obs_loads[$];
   logic [9:0]  exp_loads[$];

   always #5 clk = ~clk;

   ctrl_bm_v2 #(.WIDTH_BIN_ID(10), .WIDTH_CLAUSES(16), .WIDTH_LVL(16), .WIDTH_CNT(32),
                .TIMEOUT_CYC(8), .MAX_BKT(2)) dut (
      .clk(clk), .rst(rst), .start_bm_i(start_bm_i), .abort_i(abort_i),
      .done_bm_o(done_bm_o), .status_o(status_o), .cur_bin_num_o(cur_bin_num_o),
      .request_bin_num_o(request_bin_num_o), .cur_lvl_o(cur_lvl_o),
      .bkt_cnt_o(bkt_cnt_o), .load_cnt_o(load_cnt_o),
      .start_rdinfo_o(start_rdinfo_o), .done_rdinfo_i(done_rdinfo_i), .nbin_all_i(nbin_all_i),
      .start_load_o(start_load_o), .done_load_i(done_load_i),
      .start_core_o(start_core_o), .done_core_i(done_core_i), .local_sat_i(local_sat_i),
      .cur_lvl_from_core_i(cur_lvl_from_core_i), .bkt_bin_from_core_i(bkt_bin_from_core_i),
      .start_find_o(start_find_o), .done_find_i(done_find_i),
      .bkt_lvl_from_find_i(bkt_lvl_from_find_i), .bkt_bin_from_find_i(bkt_bin_from_find_i),
      .start_bkt_across_bin_o(start_bkt_across_bin_o), .done_bkt_across_bin_i(done_bkt_across_bin_i),
      .start_update_o(start_update_o), .done_update_i(done_update_i)
   );

   // Sub-block models: answer each start pulse on the following negedge unless told to hang.
   always @(negedge clk) begin
      st = {start_rdinfo_o, start_load_o, start_core_o, start_find_o, start_bkt_across_bin_o, start_update_o};
      if ((st & st_prev) != 6'd0) wide_cnt++;
      st_prev = st;
      done_rdinfo_i = 1'b0; done_load_i = 1'b0; done_core_i = 1'b0;
      done_find_i = 1'b0; done_bkt_across_bin_i = 1'b0; done_update_i = stray_update;
      if (load_timer == 0) begin done_load_i = 1'b1; load_timer = -1; end
      else if (load_timer > 0) load_timer--;
      if (start_rdinfo_o) done_rdinfo_i = 1'b1;
      if (start_load_o) begin
         obs_loads.push_back(request_bin_num_o);
         if (!load_hang) begin
            if (load_delay == 0) done_load_i = 1'b1;
            else load_timer = load_delay - 1;
         end
      end
      if (start_core_o && !core_hang) begin
         done_core_i = 1'b1;
         if (core_always_unsat) begin
            local_sat_i = 1'b0; bkt_bin_from_core_i = 10'd1; cur_lvl_from_core_i = 16'd0;
         end else if (core_sat_q.size() > 0) begin
            local_sat_i = core_sat_q.pop_front();
            cur_lvl_from_core_i = core_lvl_q.pop_front();
            bkt_bin_from_core_i = core_bkt_q.pop_front();
         end else begin
            local_sat_i = 1'b1; bkt_bin_from_core_i = 10'd0; cur_lvl_from_core_i = 16'd0;
         end
      end
      if (start_find_o) begin
         find_cnt++;
         done_find_i = 1'b1; bkt_bin_from_find_i = 10'd1; bkt_lvl_from_find_i = 16'd1;
      end
      if (start_bkt_across_bin_o) done_bkt_across_bin_i = 1'b1;
      if (start_update_o && !update_hang) done_update_i = 1'b1;
   end

   task automatic clear_env();
      core_sat_q.delete(); core_lvl_q.delete(); core_bkt_q.delete();
      obs_loads.delete(); exp_loads.delete();
      find_cnt = 0; load_delay = 0; load_timer = -1;
      load_hang = 1'b0; core_hang = 1'b0; update_hang = 1'b0; core_always_unsat = 1'b0;
   endtask

   task automatic push_core(input logic sat, input logic [15:0] lvl, input logic [9:0] bkt);
      core_sat_q.push_back(sat); core_lvl_q.push_back(lvl); core_bkt_q.push_back(bkt);
   endtask

   task automatic start_run(input logic [15:0] nbin);
      nbin_all_i = nbin;
      @(posedge clk); #1 start_bm_i = 1'b1;
      @(posedge clk); #1 start_bm_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done_bm_o && n < 400) begin @(posedge clk); #1 n++; end
      checks++;
      if (!done_bm_o) begin errors++; $display("FAIL %s_timeout: done_bm_o=%0b want 1 within 400 cycles", name, done_bm_o); end
   endtask

   task automatic wait_pulse(input string name, input int which);
      int n;
      n = 0;
      while (n < 100 && !((which == 0 && start_load_o) || (which == 1 && start_core_o) || (which == 2 && start_update_o))) begin
         @(posedge clk); #1 n++;
      end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL %s_pulse: start %0d not seen, got none want 1", name, which); end
   endtask

   task automatic check_loads(input string name);
      checks++;
      if (obs_loads.size() != exp_loads.size()) begin
         errors++; $display("FAIL %s_load_count: got %0d loads want %0d", name, obs_loads.size(), exp_loads.size());
      end else begin
         while (exp_loads.size() > 0) begin
            logic [9:0] e, o;
            e = exp_loads.pop_front(); o = obs_loads.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s_load_bin: got %0d want %0d", name, o, e); end
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (done_bm_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", done_bm_o); end
      checks++; if (status_o !== 2'd0) begin errors++; $display("FAIL rst_status: got %0d want 0", status_o); end
      checks++; if (cur_bin_num_o !== 10'd0) begin errors++; $display("FAIL rst_bin: got %0d want 0", cur_bin_num_o); end
      checks++; if (cur_lvl_o !== 16'd0) begin errors++; $display("FAIL rst_lvl: got %0d want 0", cur_lvl_o); end
      checks++; if (load_cnt_o !== 32'd0 || bkt_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", load_cnt_o, bkt_cnt_o); end
      @(negedge clk) rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (start_rdinfo_o !== 1'b0) begin errors++; $display("FAIL idle_no_start: got %0b want 0", start_rdinfo_o); end
   endtask

   task automatic test_all_sat();
      clear_env();
      push_core(1'b1, 16'd1, 10'd0); push_core(1'b1, 16'd2, 10'd0); push_core(1'b1, 16'd3, 10'd0);
      exp_loads.push_back(10'd1); exp_loads.push_back(10'd2); exp_loads.push_back(10'd3);
      start_run(16'd3);
      wait_done("sat");
      checks++; if (status_o !== 2'd1) begin errors++; $display("FAIL sat_status: got %0d want 1", status_o); end
      checks++; if (cur_lvl_o !== 16'd3) begin errors++; $display("FAIL sat_lvl: got %0d want 3", cur_lvl_o); end
      checks++; if (load_cnt_o !== 32'd3) begin errors++; $display("FAIL sat_load_cnt: got %0d want 3", load_cnt_o); end
      checks++; if (bkt_cnt_o !== 32'd0) begin errors++; $display("FAIL sat_bkt_cnt: got %0d want 0", bkt_cnt_o); end
      check_loads("sat");
   endtask

   task automatic test_backtrack();
      clear_env();
      push_core(1'b1, 16'd1, 10'd0); push_core(1'b0, 16'd0, 10'd1);
      push_core(1'b1, 16'd1, 10'd0); push_core(1'b1, 16'd2, 10'd0); push_core(1'b1, 16'd3, 10'd0);
      exp_loads.push_back(10'd1); exp_loads.push_back(10'd2); exp_loads.push_back(10'd1);
      exp_loads.push_back(10'd2); exp_loads.push_back(10'd3);
      start_run(16'd3);
      wait_done("bkt");
      checks++; if (status_o !== 2'd1) begin errors++; $display("FAIL bkt_status: got %0d want 1", status_o); end
      checks++; if (bkt_cnt_o !== 32'd1) begin errors++; $display("FAIL bkt_cnt: got %0d want 1", bkt_cnt_o); end
      checks++; if (load_cnt_o !== 32'd5) begin errors++; $display("FAIL bkt_load_cnt: got %0d want 5", load_cnt_o); end
      check_loads("bkt");
   endtask

   task automatic test_unsat();
      int n;
      clear_env();
      push_core(1'b0, 16'd0, 10'd0);
      start_run(16'd3);
      n = 0;
      while (!done_core_i && n < 100) begin @(posedge clk); #1 n++; end
      checks++; if (done_bm_o !== 1'b1) begin errors++; $display("FAIL unsat_done_edge: got %0b want 1", done_bm_o); end
      checks++; if (status_o !== 2'd2) begin errors++; $display("FAIL unsat_status: got %0d want 2", status_o); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (find_cnt != 0) begin errors++; $display("FAIL unsat_no_find: got %0d want 0", find_cnt); end
   endtask

   task automatic test_timeout();
      clear_env();
      load_hang = 1'b1;
      start_run(16'd3);
      wait_pulse("wd", 0);
      repeat (6) @(posedge clk);
      #1;
      checks++; if (done_bm_o !== 1'b0) begin errors++; $display("FAIL wd_early: got %0b want 0", done_bm_o); end
      @(posedge clk); #1;
      checks++; if (done_bm_o !== 1'b1) begin errors++; $display("FAIL wd_done: got %0b want 1", done_bm_o); end
      checks++; if (status_o !== 2'd3) begin errors++; $display("FAIL wd_status: got %0d want 3", status_o); end
   endtask

   task automatic test_timeout_race();
      clear_env();
      load_delay = 6;
      push_core(1'b1, 16'd5, 10'd0);
      start_run(16'd1);
      wait_done("race");
      checks++; if (status_o !== 2'd1) begin errors++; $display("FAIL race_status: got %0d want 1", status_o); end
      checks++; if (cur_lvl_o !== 16'd5) begin errors++; $display("FAIL race_lvl: got %0d want 5", cur_lvl_o); end
   endtask

   task automatic test_max_bkt();
      clear_env();
      core_always_unsat = 1'b1;
      start_run(16'd3);
      wait_done("maxbkt");
      checks++; if (status_o !== 2'd3) begin errors++; $display("FAIL maxbkt_status: got %0d want 3", status_o); end
      checks++; if (bkt_cnt_o !== 32'd2) begin errors++; $display("FAIL maxbkt_cnt: got %0d want 2", bkt_cnt_o); end
      checks++; if (find_cnt != 3) begin errors++; $display("FAIL maxbkt_finds: got %0d want 3", find_cnt); end
   endtask

   task automatic test_restart();
      clear_env();
      push_core(1'b1, 16'd1, 10'd0); push_core(1'b1, 16'd2, 10'd0);
      nbin_all_i = 16'd2;
      @(posedge clk); #1 start_bm_i = 1'b1;
      @(posedge clk); #1 start_bm_i = 1'b0;
      checks++; if (status_o !== 2'd0 || done_bm_o !== 1'b0) begin errors++; $display("FAIL rs_status: got %0d/%0b want 0/0", status_o, done_bm_o); end
      checks++; if (bkt_cnt_o !== 32'd0 || load_cnt_o !== 32'd0) begin errors++; $display("FAIL rs_cnt: got %0d/%0d want 0/0", bkt_cnt_o, load_cnt_o); end
      checks++; if (cur_bin_num_o !== 10'd1) begin errors++; $display("FAIL rs_bin: got %0d want 1", cur_bin_num_o); end
      wait_done("rs");
      checks++; if (status_o !== 2'd1) begin errors++; $display("FAIL rs_final: got %0d want 1", status_o); end
   endtask

   task automatic test_abort();
      clear_env();
      core_hang = 1'b1;
      start_run(16'd3);
      wait_pulse("abort", 1);
      abort_i = 1'b1;
      @(posedge clk); #1 abort_i = 1'b0;
      checks++; if (done_bm_o !== 1'b1 || status_o !== 2'd3) begin errors++; $display("FAIL abort: got %0b/%0d want 1/3", done_bm_o, status_o); end
   endtask

   task automatic test_stray();
      clear_env();
      core_hang = 1'b1;
      start_run(16'd3);
      wait_pulse("stray", 1);
      stray_update = 1'b1;
      @(posedge clk); #1 stray_update = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (load_cnt_o !== 32'd1) begin errors++; $display("FAIL stray_load_cnt: got %0d want 1", load_cnt_o); end
      checks++; if (cur_bin_num_o !== 10'd1 || done_bm_o !== 1'b0) begin errors++; $display("FAIL stray_state: got bin %0d done %0b want 1/0", cur_bin_num_o, done_bm_o); end
      abort_i = 1'b1;
      @(posedge clk); #1 abort_i = 1'b0;
      checks++; if (status_o !== 2'd3) begin errors++; $display("FAIL stray_abort: got %0d want 3", status_o); end
   endtask

   task automatic test_reset_mid();
      clear_env();
      update_hang = 1'b1;
      push_core(1'b1, 16'd4, 10'd0);
      start_run(16'd3);
      wait_pulse("rstmid", 2);
      #2 rst = 1'b0;
      #1;
      checks++; if (start_update_o !== 1'b0) begin errors++; $display("FAIL rstmid_pulse: got %0b want 0", start_update_o); end
      checks++; if (cur_lvl_o !== 16'd0 || cur_bin_num_o !== 10'd0) begin errors++; $display("FAIL rstmid_regs: got %0d/%0d want 0/0", cur_lvl_o, cur_bin_num_o); end
      checks++; if (load_cnt_o !== 32'd0 || status_o !== 2'd0 || done_bm_o !== 1'b0) begin errors++; $display("FAIL rstmid_out: got %0d/%0d/%0b want 0/0/0", load_cnt_o, status_o, done_bm_o); end
      @(negedge clk) rst = 1'b1;
      update_hang = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_pulse_width();
      #1;
      checks++; if (wide_cnt != 0) begin errors++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_cnt); end
   endtask

   initial begin
      test_reset();
      test_all_sat();
      test_backtrack();
      test_unsat();
      test_timeout();
      test_timeout_race();
      test_max_bkt();
      test_restart();
      test_abort();
      test_stray();
      test_reset_mid();
      test_pulse_width();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ctrl_bm_v2.md
# ctrl_bm_v2

Parametrised, restartable sequencer for the Bin_Manager. It runs the read-info → load → core → (find → backtrack) → update loop over all bins and reports the global SAT or UNSAT result. It adds three things the first-generation controller lacks: a per-stage watchdog, a backtrack budget and an external abort. It sits between the top-level solver control and the rdinfo, load, sat_engine core, find_global_bkt_lvl, bkt_across_bin and update sub-blocks, and drives each of them with a one-cycle start pulse / done handshake.

## Interface
- WIDTH_BIN_ID, 10: bin number width.
- WIDTH_CLAUSES, 16: width of the bin count from rdinfo.
- WIDTH_LVL, 16: decision-level width.
- WIDTH_CNT, 32: width of the watchdog, backtrack and load counters.
- TIMEOUT_CYC, 0: maximum cycles per stage without done. 0 disables the watchdog.
- MAX_BKT, 0: maximum backtracks per run. 0 means unlimited.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_bm_i  in  1  start a run; sampled in IDLE or DONE.
- abort_i  in  1  request abort; level-sensitive.
- done_bm_o  out  1  high while in DONE.
- status_o  out  2  run result: 0 none, 1 SAT, 2 UNSAT, 3 ABORT.
- cur_bin_num_o  out  WIDTH_BIN_ID  current bin; also drives request_bin_num_o.
- request_bin_num_o  out  WIDTH_BIN_ID  bin number for load and update.
- cur_lvl_o  out  WIDTH_LVL  current global level.
- bkt_cnt_o, load_cnt_o  out  WIDTH_CNT  backtracks taken and loads issued in the current run.
- start_rdinfo_o / done_rdinfo_i, nbin_all_i (in, WIDTH_CLAUSES): read-info handshake and bin count.
- start_load_o / done_load_i: load handshake.
- start_core_o / done_core_i, local_sat_i, cur_lvl_from_core_i (WIDTH_LVL), bkt_bin_from_core_i (WIDTH_BIN_ID): core handshake and result.
- start_find_o / done_find_i, bkt_lvl_from_find_i (WIDTH_LVL), bkt_bin_from_find_i (WIDTH_BIN_ID): find handshake and backtrack target.
- start_bkt_across_bin_o / done_bkt_across_bin_i: backtrack handshake.
- start_update_o / done_update_i: update handshake.

## Operation
States: IDLE, RD_INFO, LOAD, CORE, FIND, BKT, UPDATE, DONE.

Transitions:
- IDLE --start_bm_i--> RD_INFO. Entering RD_INFO clears status_o, both counters, cur_lvl_o, and sets cur_bin = 1.
- RD_INFO --done_rdinfo_i--> LOAD. If nbin_all_i == 0, go to DONE with status 1 instead. nbin_all_i is latched on done.
- LOAD --done_load_i--> CORE. load_cnt increments on the start_load_o pulse.
- CORE --done_core_i-->:
  - local_sat_i and cur_bin == nbin_all → DONE, status 1.
  - local_sat_i otherwise → UPDATE, with next_bin = cur_bin + 1.
  - unsat and bkt_bin_from_core_i == 0 → DONE, status 2.
  - unsat otherwise → FIND.
- FIND --done_find_i--> BKT. Latch next_bin = bkt_bin_from_find_i. If MAX_BKT != 0 and bkt_cnt == MAX_BKT, go to DONE with status 3 instead. Otherwise bkt_cnt increments.
- BKT --done_bkt_across_bin_i--> UPDATE.
- UPDATE --done_update_i--> LOAD, with cur_bin <= next_bin. The update uses request_bin_num_o = old cur_bin.
- DONE --start_bm_i--> RD_INFO, which restarts the run. DONE otherwise holds.

Level tracking:
- cur_lvl_o <= cur_lvl_from_core_i on an accepted done_core_i with local_sat_i.
- cur_lvl_o <= bkt_lvl_from_find_i on an accepted done_find_i.

Done qualification: done inputs count only in their own state. Stray dones in any other state are ignored and change nothing.

Watchdog:
- stage_cnt clears on every state entry and increments each cycle in RD_INFO through UPDATE.
- If TIMEOUT_CYC != 0 and stage_cnt == TIMEOUT_CYC − 1 with no done that cycle → DONE, status 3.

Abort and priority:
- abort_i high in any state other than IDLE or DONE → DONE, status 3 on the next edge.
- Priority order: abort_i > done > watchdog.

Width rule: cur_bin + 1 wraps modulo 2^WIDTH_BIN_ID. The wrap is unreachable when nbin_all < 2^WIDTH_BIN_ID.

## Timing
- Reset: all outputs and counters are 0 and the state is IDLE. Reset takes effect immediately and asynchronously, including mid-run, and any pending start pulse is killed.
- A state is entered at edge k. Its start pulse is registered and is high for exactly one cycle, between edges k+1 and k+2. It is re-issued on every entry, including a re-entry into LOAD.
- A done sampled at edge j makes the next state and all latched values (cur_bin, cur_lvl_o, counters, status_o) valid after edge j.
- A done is accepted even in the cycle its start pulse is high, so the minimum stage length is 2 cycles.
- done_bm_o and status_o are registered. They change on the edge that enters DONE and hold until restart or reset.

## Test plan
- nbin_all = 3, every core returns local_sat with levels 1, 2, 3 → loads of bins 1, 2, 3; status 1; cur_lvl_o = 3; load_cnt = 3; bkt_cnt = 0.
- nbin_all = 3; bin 2 returns unsat with bkt_bin_from_core = 1; find returns bin 1, level 1; then all sat → load sequence 1, 2, 1, 2, 3; bkt_cnt = 1; status 1.
- Core unsat with bkt_bin_from_core = 0 on bin 1 → status 2; done_bm_o high 1 cycle after done_core_i; no find pulse.
- TIMEOUT_CYC = 8, done_load_i never arrives → status 3 exactly 8 cycles after LOAD entry. Same setup with done and timeout in the same cycle → CORE entered, no abort.
- MAX_BKT = 2 with a core that always returns unsat with bkt_bin_from_core = 1 → third find completion ends the run with status 3 and bkt_cnt = 2. abort_i asserted in CORE → status 3 next edge.
- Start pulses are exactly 1 cycle wide; stray done_update_i while in CORE is ignored. rst asserted mid-UPDATE → all outputs 0 asynchronously. start_bm_i in DONE → counters cleared and status_o = 0 on entry to RD_INFO.
